// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Generates VGA raster timing from a free-running horizontal/vertical
// counter pair and produces blanked, registered colour and sync outputs.
// The sync and blanking flags are delayed to match the latency of the
// downstream pixel generator.
//
// Ports
//   pixel_clk    in   1   pixel clock
//   rst_n        in   1   synchronous active-low reset
//   h_coord      out  10  horizontal counter, 0..H_TOTAL-1
//   v_coord      out  10  vertical counter, 0..V_TOTAL-1
//   display_on   out  1   high inside the visible area
//   frame_start  out  1   one-cycle pulse at (0,0)
//   frame_cnt    out  16  completed frames, wraps modulo 2^16
//   rgb_in       in   12  {r,g,b} from the pixel generator, PIPE_DLY cycles
//                         behind the coordinates
//   vga_r/g/b    out  4   blanked registered colour
//   vga_hs/vs    out  1   registered syncs, level SYNC_POL when asserted
//
// Sequencing FSM
//   state  | meaning
//   ST_ARM | first cycle after reset; counters hold (0,0) while the
//          | registered flags for (0,0) are loaded
//   ST_RUN | counters advance every cycle
module vga_timing_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 72,
    parameter int   H_BP     = 128,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 22,
    parameter logic SYNC_POL = 1'b1,
    parameter int   PIPE_DLY = 1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    output logic [9:0]  h_coord,
    output logic [9:0]  v_coord,
    output logic        display_on,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    input  logic [11:0] rgb_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   advance;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state <= ST_ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARM:  state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_ARM;
        endcase
    end

    always_comb begin
        advance = (state == ST_RUN);
    end

    // Next counter position; the registered flags are computed from it so
    // they line up with h_coord/v_coord in the same cycle.
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       frame_wrap;

    always_comb begin
        h_nxt      = h_coord;
        v_nxt      = v_coord;
        frame_wrap = 1'b0;
        if (advance) begin
            if (h_coord == H_LAST) begin
                h_nxt = '0;
                if (v_coord == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = v_coord + 10'd1;
                end
            end else begin
                h_nxt = h_coord + 10'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            h_coord     <= '0;
            v_coord     <= '0;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_coord     <= h_nxt;
            v_coord     <= v_nxt;
            display_on  <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    logic hs_raw;
    logic vs_raw;

    always_comb begin
        hs_raw = (h_coord >= HS_START) && (h_coord < HS_END);
        vs_raw = (v_coord >= VS_START) && (v_coord < VS_END);
    end

    // {display_on, vsync, hsync} delayed to match the pixel generator.
    logic [2:0] tap_raw;
    logic [2:0] tap_dly;

    assign tap_raw = {display_on, vs_raw, hs_raw};

    if (PIPE_DLY == 0) begin : g_no_dly
        assign tap_dly = tap_raw;
    end else begin : g_dly
        logic [2:0] sr [PIPE_DLY];

        always_ff @(posedge pixel_clk) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    sr[i] <= '0;
                end
            end else begin
                sr[0] <= tap_raw;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign tap_dly = sr[PIPE_DLY-1];
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else begin
            vga_r  <= tap_dly[2] ? rgb_in[11:8] : 4'd0;
            vga_g  <= tap_dly[2] ? rgb_in[7:4]  : 4'd0;
            vga_b  <= tap_dly[2] ? rgb_in[3:0]  : 4'd0;
            vga_hs <= tap_dly[0] ? SYNC_POL : ~SYNC_POL;
            vga_vs <= tap_dly[1] ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 72, hsync width in pixels.
REQ-004 Parameter H_BP, default 128, horizontal back porch; H_TOTAL = sum of the four horizontal parameters = 1024.
REQ-005 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync width in lines.
REQ-008 Parameter V_BP, default 22, vertical back porch; V_TOTAL = sum of the four vertical parameters = 625.
REQ-009 Parameter SYNC_POL, default 1, asserted level of hsync and vsync; 1 means active-high.
REQ-010 Parameter PIPE_DLY, default 1, range 0..3, latency in cycles of the downstream pixel generator from coordinates to RGB.
REQ-011 pixel_clk  in  1  pixel clock, 36 MHz; reset rst_n is synchronous, active-low, on clock pixel_clk.
REQ-012 rst_n  in  1  synchronous active-low reset.
REQ-013 h_coord  out  10  current horizontal counter, 0..H_TOTAL-1.
REQ-014 v_coord  out  10  current vertical counter, 0..V_TOTAL-1.
REQ-015 display_on  out  1  high when h_coord < H_ACTIVE and v_coord < V_ACTIVE.
REQ-016 frame_start  out  1  one-cycle pulse while h_coord==0 and v_coord==0.
REQ-017 frame_cnt  out  16  count of completed frames.
REQ-018 rgb_in  in  12  {r,g,b} 4 bits each, from the pixel generator, valid PIPE_DLY cycles after the matching coordinates.
REQ-019 vga_r, vga_g, vga_b  out  4 each  blanked, registered colour to the DAC.
REQ-020 vga_hs, vga_vs  out  1 each  registered syncs aligned with vga_r, vga_g and vga_b.

Function
REQ-021 h_coord SHALL increment by 1 every cycle and wrap from H_TOTAL-1 (1023) to 0.
REQ-022 v_coord SHALL increment only on the cycle h_coord wraps, and SHALL wrap from V_TOTAL-1 (624) to 0 on that same cycle.
REQ-023 The raw hsync SHALL be asserted for H_ACTIVE+H_FP <= h_coord < H_ACTIVE+H_FP+H_SYNC, i.e. 824..895.
REQ-024 The raw vsync SHALL be asserted for V_ACTIVE+V_FP <= v_coord < V_ACTIVE+V_FP+V_SYNC, i.e. 601..602, over the full line.
REQ-025 display_on, h_coord, v_coord and frame_start SHALL be registered outputs, all derived from the same counter state.
REQ-026 frame_cnt SHALL increment by 1, modulo 2^16, on the cycle where h_coord goes from 1023 to 0 and v_coord goes from 624 to 0.
REQ-027 Raw hsync, raw vsync and display_on SHALL pass through a PIPE_DLY-stage shift register; PIPE_DLY=0 means no delay stages.
REQ-028 The output stage SHALL register rgb_in into vga_r/g/b when the delayed display_on is 1, and SHALL register 0 otherwise.
REQ-029 The output stage SHALL register the delayed syncs into vga_hs and vga_vs, driving level SYNC_POL when the sync is asserted and ~SYNC_POL when it is not.
REQ-030 Total latency from coordinates to the vga_* outputs SHALL be PIPE_DLY+1 cycles, identical for colour and sync.
REQ-031 The block SHALL use no arithmetic wider than 10 bits for coordinate compares.
REQ-032 All parameter-derived constants SHALL be computed at elaboration time.

Reset
REQ-033 While rst_n=0: h_coord=0, v_coord=0, frame_cnt=0, display_on=0, frame_start=0, all delay stages cleared, vga_r/g/b=0, vga_hs=vga_vs=~SYNC_POL.
REQ-034 On the first clock with rst_n=1, counters SHALL start counting from (0,0); display_on=1 and frame_start=1 on the following cycle.
REQ-035 Reset asserted mid-frame SHALL take effect on the next clock edge, with no partial line completed and no frame_cnt increment.

Verification
REQ-036 Free run for 2 frames: hs period 1024 cycles, hs high for 72 cycles, vs period 640000 cycles, vs high for 2048 cycles, display_on high for 480000 cycles per frame.
REQ-037 h_coord=1023, v_coord=624 -> next cycle (0,0), frame_start=1, frame_cnt increments by 1; frame_cnt at 0xFFFF wraps to 0x0000.
REQ-038 PIPE_DLY=1, rgb_in=12'hFFF constant -> first vga_r=4'hF occurs 2 cycles after (0,0); vga_r=0 at the cycle aligned to h_coord=800.
REQ-039 PIPE_DLY=0 and PIPE_DLY=3 -> vga_hs rising edge lags h_coord==824 by 1 and 4 cycles respectively.
REQ-040 SYNC_POL=0 -> vga_hs low only during the 72-cycle window and high in reset.
REQ-041 rst_n pulsed low for 1 cycle at (500,300) -> next cycle (0,0) with all outputs at reset values, frame_cnt unchanged from 0 after restart.
